// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit ALU, with one operation in flight at a time.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win ties; otherwise ties are round-robin.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shamt,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        rsp1_err
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1101;
    localparam logic [3:0] OP_SRL = 4'b1110;

    typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t      state_r;
    logic        owner_r;
    logic [3:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [4:0]  shamt_r;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic        last_r;
`endif

    logic        grant0_s;
    logic        grant1_s;
    logic        act0_s;
    logic        act1_s;
    logic [31:0] alu_res_s;
    logic        alu_err_s;

    // Grant selection; only offered while idle and out of reset.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst && state_r == IDLE) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0_s = req0_valid;
            grant1_s = req1_valid && !req0_valid;
`else
            // last_r high means requester 1 was granted last, so 0 wins a tie.
            grant0_s = req0_valid && (!req1_valid || last_r);
            grant1_s = req1_valid && (!req0_valid || !last_r);
`endif
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Shared ALU, fed only from the captured operands.
    always_comb begin
        alu_res_s = 32'd0;
        alu_err_s = 1'b0;
        case (op_r)
            OP_AND:  alu_res_s = a_r & b_r;
            OP_OR:   alu_res_s = a_r | b_r;
            OP_ADD:  alu_res_s = a_r + b_r;
            OP_SUB:  alu_res_s = a_r - b_r;
            OP_SLT:  alu_res_s = (a_r < b_r) ? 32'd1 : 32'd0;
            OP_NOR:  alu_res_s = ~(a_r | b_r);
            OP_SLL:  alu_res_s = a_r << shamt_r;
            OP_SRL:  alu_res_s = a_r >> shamt_r;
            default: begin
                alu_res_s = 32'd0;
                alu_err_s = 1'b1;
            end
        endcase
    end

    assign act0_s = (state_r == RESP) && (owner_r == 1'b0);
    assign act1_s = (state_r == RESP) && (owner_r == 1'b1);

    // Response outputs are forced to zero unless that requester owns the pending result.
    always_comb begin
        rsp0_valid  = act0_s;
        rsp1_valid  = act1_s;
        rsp0_result = 32'd0;
        rsp0_zero   = 1'b0;
        rsp0_err    = 1'b0;
        rsp1_result = 32'd0;
        rsp1_zero   = 1'b0;
        rsp1_err    = 1'b0;
        if (act0_s) begin
            rsp0_result = alu_res_s;
            rsp0_zero   = (alu_res_s == 32'd0);
            rsp0_err    = alu_err_s;
        end else begin
            rsp0_result = 32'd0;
        end
        if (act1_s) begin
            rsp1_result = alu_res_s;
            rsp1_zero   = (alu_res_s == 32'd0);
            rsp1_err    = alu_err_s;
        end else begin
            rsp1_result = 32'd0;
        end
    end

    // Control FSM and operand capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            op_r    <= 4'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            shamt_r <= 5'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_r  <= 1'b1;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant0_s) begin
                        op_r    <= req0_op;
                        a_r     <= req0_a;
                        b_r     <= req0_b;
                        shamt_r <= req0_shamt;
                        owner_r <= 1'b0;
                        state_r <= RESP;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_r  <= 1'b0;
`endif
                    end else if (grant1_s) begin
                        op_r    <= req1_op;
                        a_r     <= req1_a;
                        b_r     <= req1_b;
                        shamt_r <= req1_shamt;
                        owner_r <= 1'b1;
                        state_r <= RESP;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_r  <= 1'b1;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RESP: begin
                    if ((act0_s && rsp0_ready) || (act1_s && rsp1_ready)) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits, opcode 4 bits, shift amount 5 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_op  input  4  ALU control code: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt (unsigned), 1100 nor, 1101 sll, 1110 srl.
REQ-007 reqN_a, reqN_b  input  32 each  first and second operands.
REQ-008 reqN_shamt  input  5  shift amount.
REQ-009 rspN_valid  output  1  response for requester N is available.
REQ-010 rspN_ready  input  1  requester N consumes the response.
REQ-011 rspN_result  output  32  ALU result.
REQ-012 rspN_zero  output  1  high when rspN_result == 0.
REQ-013 rspN_err  output  1  high when the accepted opcode is outside REQ-006.

Function
REQ-014 The block SHALL contain exactly one shared 32-bit ALU implementing REQ-006 and SHALL allow at most one operation in flight.
REQ-015 FSM states SHALL be IDLE and RESP.
- IDLE: at most one reqN_ready high, combinationally, for the granted valid requester.
- RESP: both reqN_ready low.
REQ-016 In IDLE, when exactly one reqN_valid is high, that requester SHALL be granted.
REQ-017 In IDLE, when both are valid, the requester not granted last SHALL win (round-robin); the last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-018 On the edge where reqN_valid && reqN_ready, the block SHALL:
- register op, a, b and shamt;
- record owner N;
- move to RESP.
REQ-019 In RESP, only the owner's rspN_valid SHALL be high, starting the cycle after acceptance (latency 1 cycle); the other rsp valid SHALL stay low.
REQ-020 rspN_result, rspN_zero and rspN_err SHALL derive only from the registered operands and SHALL stay stable while rspN_valid && !rspN_ready.
REQ-021 On the edge where the owner's rspN_valid && rspN_ready, the FSM SHALL return to IDLE. No new acceptance SHALL occur in that same cycle, so the maximum throughput is one operation per 2 cycles.
REQ-022 Arithmetic SHALL be modulo 2^32; add/sub overflow SHALL be ignored; slt SHALL be an unsigned compare giving 1 or 0.
REQ-023 Shifts SHALL use only the registered shamt and be logical (zero fill).
REQ-024 For an unsupported opcode, the block SHALL return result 0, zero=1 and err=1; no X SHALL propagate to outputs.
REQ-025 rspN_result, rspN_zero and rspN_err SHALL drive 0 when rspN_valid is low.
REQ-026 reqN_valid deasserting while not accepted SHALL have no effect on state.

Reset
REQ-027 While rst is high, the block SHALL hold: state IDLE, last-grant=1, all rspN_valid=0, all rsp data 0, operand registers 0. All reqN_ready SHALL be 0 while rst is asserted.
REQ-028 A reset asserted in RESP SHALL discard the pending response with no rsp handshake.
REQ-029 After rst deasserts, arbitration SHALL resume in IDLE on the first clk edge.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN:
- Defined: requester 0 SHALL always win ties and the last-grant register SHALL be absent.
- Undefined: round-robin per REQ-017.

Verification
REQ-031 Reset, then req0: op=0010, a=5, b=7 -> rsp0_valid the next cycle, result=12, zero=0, err=0.
REQ-032 Both valid every IDLE cycle, rsp ready held high -> grants alternate 0,1,0,1; one grant every 2 cycles; with ALU_ARB_FIXED_PRIO_EN defined, grants are all 0.
REQ-033 req1: op=0110, a=b=32'hFFFFFFFF -> result=0, zero=1; then op=1101, a=1, shamt=31 -> result=32'h80000000.
REQ-034 req0: op=0011 -> result=0, zero=1, err=1; hold rsp0_ready low 5 cycles -> outputs stable, both reqN_ready low throughout.
REQ-035 Assert rst during RESP -> rsp0_valid drops immediately (asynchronously); after release, a pending req1 is accepted on the first clk edge.
REQ-036 req0: op=0111, a=3, b=32'hFFFFFFFE -> result=1 (unsigned compare).
